// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the serial-bus arbiter/router.
package bus_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_ADDR,
    ST_CONNECTED,
    ST_RELEASE
  } state_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Index width that stays at least one bit for single-entry vectors.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational one-hot picker: lowest index in fixed mode, or first
// requester after the pointer (wrapping) in round-robin mode.
module rr_priority_picker #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          rr_mode,
  output logic [N-1:0]  gnt,
  output logic          vld
);

  always_comb begin
    logic [PW-1:0] idx;
    gnt = '0;
    vld = 1'b0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      idx = rr_mode ? PW'((int'(ptr) + 1 + i) % N) : PW'(i);
      if (!vld && req[idx]) begin
        gnt[idx] = 1'b1;
        vld      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_nm.sv
// Serial-bus arbiter/router: grants one master, shifts in a slave select,
// then routes the serial handshake; holds one split transaction for resume.
module bus_arbiter_nm
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS  = 2,
  parameter int NUM_SLAVES   = 4,
  parameter int SEL_W        = 2,
  parameter int ARB_MODE     = 0,
  parameter int ADDR_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] m_breq,
  output logic [NUM_MASTERS-1:0] m_bgrant,
  input  logic [NUM_MASTERS-1:0] m_mode,
  input  logic [NUM_MASTERS-1:0] m_wr_bus,
  input  logic [NUM_MASTERS-1:0] m_master_valid,
  input  logic [NUM_MASTERS-1:0] m_master_ready,
  output logic [NUM_MASTERS-1:0] m_rd_bus,
  output logic [NUM_MASTERS-1:0] m_ack,
  output logic [NUM_MASTERS-1:0] m_slave_ready,
  output logic [NUM_MASTERS-1:0] m_slave_valid,
  output logic [NUM_MASTERS-1:0] m_split,
  output logic [NUM_SLAVES-1:0]  s_mode,
  output logic [NUM_SLAVES-1:0]  s_wr_bus,
  output logic [NUM_SLAVES-1:0]  s_master_valid,
  output logic [NUM_SLAVES-1:0]  s_master_ready,
  input  logic [NUM_SLAVES-1:0]  s_rd_bus,
  input  logic [NUM_SLAVES-1:0]  s_slave_ready,
  input  logic [NUM_SLAVES-1:0]  s_slave_valid,
  input  logic [NUM_SLAVES-1:0]  s_split
);

  localparam int OW  = idx_w(NUM_MASTERS);
  localparam int CW  = $clog2(SEL_W + 1);
  localparam int TW  = $clog2(ADDR_TIMEOUT + 1);
  localparam int NMP = 2 ** OW;
  localparam int NSP = 2 ** SEL_W;

  state_e            state_q, state_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [OW-1:0]     split_owner_q, split_owner_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  split_slave_q, split_slave_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     to_q, to_d;
  logic              split_pend_q, split_pend_d;

  // Zero-padded copies so owner/sel can index without range issues.
  logic [NMP-1:0] m_breq_p, m_valid_p, m_wr_p, m_mode_p, m_mready_p;
  logic [NSP-1:0] s_split_p, s_rd_p, s_rdy_p, s_vld_p;

  assign m_breq_p   = NMP'(m_breq);
  assign m_valid_p  = NMP'(m_master_valid);
  assign m_wr_p     = NMP'(m_wr_bus);
  assign m_mode_p   = NMP'(m_mode);
  assign m_mready_p = NMP'(m_master_ready);
  assign s_split_p  = NSP'(s_split);
  assign s_rd_p     = NSP'(s_rd_bus);
  assign s_rdy_p    = NSP'(s_slave_ready);
  assign s_vld_p    = NSP'(s_slave_valid);

  logic own_breq, own_valid, own_wr;
  assign own_breq  = m_breq_p[owner_q];
  assign own_valid = m_valid_p[owner_q];
  assign own_wr    = m_wr_p[owner_q];

  logic [NUM_MASTERS-1:0] excl, pick_req, pick_gnt;
  logic                   pick_vld;
  logic [OW-1:0]          win_idx;

  // The parked split owner may not win a fresh arbitration.
  assign excl     = split_pend_q ? (NUM_MASTERS'(1) << split_owner_q) : '0;
  assign pick_req = m_breq & ~excl;

  rr_priority_picker #(
    .N  (NUM_MASTERS),
    .PW (OW)
  ) u_picker (
    .req     (pick_req),
    .ptr     (rr_ptr_q),
    .rr_mode (ARB_MODE == ARB_RR),
    .gnt     (pick_gnt),
    .vld     (pick_vld)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick_gnt[i]) win_idx = OW'(i);
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    split_owner_d = split_owner_q;
    split_slave_d = split_slave_q;
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    to_d          = to_q;
    split_pend_d  = split_pend_q;
    case (state_q)
      ST_IDLE: begin
        if (split_pend_q && !s_split_p[split_slave_q]) begin
          owner_d      = split_owner_q;
          sel_d        = split_slave_q;
          split_pend_d = 1'b0;
          state_d      = ST_CONNECTED;
        end else if (pick_vld) begin
          owner_d = win_idx;
          if (ARB_MODE == ARB_RR) rr_ptr_d = win_idx;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT, ST_ADDR: begin
        if (!own_breq) begin
          state_d = ST_RELEASE;
        end else if (!own_valid) begin
          to_d = to_q + TW'(1);
          if (to_d == TW'(ADDR_TIMEOUT)) state_d = ST_RELEASE;
        end else begin
          // Select bits arrive MSB-first; sel and cnt are zero on entry.
          to_d  = '0;
          sel_d = SEL_W'({sel_q, own_wr});
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CW'(SEL_W)) begin
            state_d = (int'(sel_d) < NUM_SLAVES) ? ST_CONNECTED : ST_RELEASE;
          end else begin
            state_d = ST_ADDR;
          end
        end
      end
      ST_CONNECTED: begin
        if (!own_breq) begin
          state_d = ST_RELEASE;
        end else if (s_split_p[sel_q] && !split_pend_q) begin
          split_owner_d = owner_q;
          split_slave_d = sel_q;
          split_pend_d  = 1'b1;
          state_d       = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        cnt_d   = '0;
        sel_d   = '0;
        to_d    = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      owner_q       <= '0;
      rr_ptr_q      <= OW'(NUM_MASTERS - 1);
      split_owner_q <= '0;
      split_slave_q <= '0;
      sel_q         <= '0;
      cnt_q         <= '0;
      to_q          <= '0;
      split_pend_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      split_owner_q <= split_owner_d;
      split_slave_q <= split_slave_d;
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
      to_q          <= to_d;
      split_pend_q  <= split_pend_d;
    end
  end

  logic granted, connected;
  assign granted   = (state_q == ST_GRANT) || (state_q == ST_ADDR) || connected;
  assign connected = (state_q == ST_CONNECTED);

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_master
    logic own_i;
    assign own_i            = (owner_q == OW'(i));
    assign m_bgrant[i]      = granted && own_i;
    assign m_ack[i]         = connected && own_i;
    assign m_slave_ready[i] = own_i && ((state_q == ST_ADDR) || (connected && s_rdy_p[sel_q]));
    assign m_slave_valid[i] = connected && own_i && s_vld_p[sel_q];
    assign m_rd_bus[i]      = connected && own_i && s_rd_p[sel_q];
    assign m_split[i]       = split_pend_q && s_split_p[split_slave_q] &&
                              (split_owner_q == OW'(i));
  end

  for (genvar j = 0; j < NUM_SLAVES; j++) begin : g_slave
    logic sel_j;
    assign sel_j             = connected && (sel_q == SEL_W'(j));
    assign s_mode[j]         = sel_j && m_mode_p[owner_q];
    assign s_wr_bus[j]       = sel_j && m_wr_p[owner_q];
    assign s_master_valid[j] = sel_j && m_valid_p[owner_q];
    assign s_master_ready[j] = sel_j && m_mready_p[owner_q];
  end

endmodule

// File: tb/tb_bus_arbiter_nm.sv
// Randomized bench: a fixed-priority and a round-robin arbiter share stimulus
// and are each compared every cycle against a transaction-level model.
module tb_bus_arbiter_nm;

  localparam int NM = 4;
  localparam int NS = 3;
  localparam int SW = 2;
  localparam int TO = 8;

  localparam int P_IDLE = 0, P_GRANT = 1, P_ADDR = 2, P_CONN = 3, P_REL = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [NM-1:0] m_breq = '0, m_mode = '0, m_wr_bus = '0;
  logic [NM-1:0] m_master_valid = '0, m_master_ready = '0;
  logic [NS-1:0] s_rd_bus = '0, s_slave_ready = '0, s_slave_valid = '0, s_split = '0;

  logic [NM-1:0] bgrant [2], rd_bus [2], ack [2], sready [2], svalid [2], msplit [2];
  logic [NS-1:0] smode [2], swr [2], smv [2], smr [2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    bus_arbiter_nm #(
      .NUM_MASTERS (NM), .NUM_SLAVES (NS), .SEL_W (SW),
      .ARB_MODE (k), .ADDR_TIMEOUT (TO)
    ) u_dut (
      .clk (clk), .rstn (rstn),
      .m_breq (m_breq), .m_bgrant (bgrant[k]), .m_mode (m_mode),
      .m_wr_bus (m_wr_bus), .m_master_valid (m_master_valid),
      .m_master_ready (m_master_ready), .m_rd_bus (rd_bus[k]), .m_ack (ack[k]),
      .m_slave_ready (sready[k]), .m_slave_valid (svalid[k]), .m_split (msplit[k]),
      .s_mode (smode[k]), .s_wr_bus (swr[k]), .s_master_valid (smv[k]),
      .s_master_ready (smr[k]), .s_rd_bus (s_rd_bus), .s_slave_ready (s_slave_ready),
      .s_slave_valid (s_slave_valid), .s_split (s_split)
    );
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model state, one set per instance (index 1 = round-robin).
  int ph [2], own [2], sel [2], nbits [2], idle [2];
  int sp_pend [2], sp_own [2], sp_slv [2], last [2];

  task automatic mdl_reset(input int k);
    ph[k] = P_IDLE; own[k] = 0; sel[k] = 0; nbits[k] = 0; idle[k] = 0;
    sp_pend[k] = 0; sp_own[k] = 0; sp_slv[k] = 0; last[k] = NM - 1;
  endtask

  task automatic mdl_step(input int k);
    int w, m;
    case (ph[k])
      P_IDLE: begin
        if (sp_pend[k] != 0 && s_split[sp_slv[k]] == 1'b0) begin
          own[k] = sp_own[k]; sel[k] = sp_slv[k]; sp_pend[k] = 0; ph[k] = P_CONN;
        end else begin
          w = -1;
          for (int off = 0; off < NM; off++) begin
            m = (k == 1) ? (last[k] + 1 + off) % NM : off;
            if (w < 0 && m_breq[m] && !(sp_pend[k] != 0 && m == sp_own[k])) w = m;
          end
          if (w >= 0) begin
            own[k] = w; ph[k] = P_GRANT;
            if (k == 1) last[k] = w;
          end
        end
      end
      P_GRANT, P_ADDR: begin
        if (!m_breq[own[k]]) ph[k] = P_REL;
        else if (!m_master_valid[own[k]]) begin
          idle[k]++;
          if (idle[k] >= TO) ph[k] = P_REL;
        end else begin
          idle[k] = 0;
          sel[k] = sel[k] * 2 + int'(m_wr_bus[own[k]]);
          nbits[k]++;
          if (nbits[k] == SW) ph[k] = (sel[k] < NS) ? P_CONN : P_REL;
          else ph[k] = P_ADDR;
        end
      end
      P_CONN: begin
        if (!m_breq[own[k]]) ph[k] = P_REL;
        else if (s_split[sel[k]] && sp_pend[k] == 0) begin
          sp_own[k] = own[k]; sp_slv[k] = sel[k]; sp_pend[k] = 1; ph[k] = P_REL;
        end
      end
      default: begin
        sel[k] = 0; nbits[k] = 0; idle[k] = 0; ph[k] = P_IDLE;
      end
    endcase
  endtask

  task automatic compare_all();
    logic [NM-1:0] e_gnt, e_ack, e_sr, e_sv, e_rd, e_sp;
    logic [NS-1:0] e_mode, e_wr, e_mv, e_mr;
    for (int k = 0; k < 2; k++) begin
      e_gnt = '0; e_ack = '0; e_sr = '0; e_sv = '0; e_rd = '0; e_sp = '0;
      e_mode = '0; e_wr = '0; e_mv = '0; e_mr = '0;
      if (ph[k] == P_GRANT || ph[k] == P_ADDR || ph[k] == P_CONN) e_gnt[own[k]] = 1'b1;
      if (ph[k] == P_ADDR) e_sr[own[k]] = 1'b1;
      if (ph[k] == P_CONN) begin
        e_ack[own[k]]  = 1'b1;
        e_sr[own[k]]   = s_slave_ready[sel[k]];
        e_sv[own[k]]   = s_slave_valid[sel[k]];
        e_rd[own[k]]   = s_rd_bus[sel[k]];
        e_mode[sel[k]] = m_mode[own[k]];
        e_wr[sel[k]]   = m_wr_bus[own[k]];
        e_mv[sel[k]]   = m_master_valid[own[k]];
        e_mr[sel[k]]   = m_master_ready[own[k]];
      end
      if (sp_pend[k] != 0 && s_split[sp_slv[k]]) e_sp[sp_own[k]] = 1'b1;
      chk(k ? "rr_grant" : "fx_grant", 64'(bgrant[k]), 64'(e_gnt));
      chk(k ? "rr_mside" : "fx_mside",
          64'({ack[k], sready[k], svalid[k], rd_bus[k], msplit[k]}),
          64'({e_ack, e_sr, e_sv, e_rd, e_sp}));
      chk(k ? "rr_sside" : "fx_sside",
          64'({smode[k], swr[k], smv[k], smr[k]}), 64'({e_mode, e_wr, e_mv, e_mr}));
    end
  endtask

  task automatic compare_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk(tag, 64'({bgrant[k], rd_bus[k], ack[k], sready[k], svalid[k], msplit[k],
                    smode[k], swr[k], smv[k], smr[k]}), 64'd0);
    end
  endtask

  task automatic drive_inputs(input int pb, input int pv);
    for (int i = 0; i < NM; i++) begin
      m_breq[i]         = ($urandom_range(99) < pb);
      m_master_valid[i] = ($urandom_range(99) < pv);
      m_wr_bus[i]       = $urandom_range(1);
      m_mode[i]         = $urandom_range(1);
      m_master_ready[i] = $urandom_range(1);
    end
    for (int j = 0; j < NS; j++) begin
      s_rd_bus[j]      = $urandom_range(1);
      s_slave_ready[j] = $urandom_range(1);
      s_slave_valid[j] = $urandom_range(1);
      if ($urandom_range(99) < 4) s_split[j] = ~s_split[j];
    end
  endtask

  // Called just after a rising edge; leaves the bench just after the next one.
  task automatic run_cycles(input int n, input int pb, input int pv);
    for (int c = 0; c < n; c++) begin
      drive_inputs(pb, pv);
      @(negedge clk);
      compare_all();
      @(posedge clk);
      mdl_step(0);
      mdl_step(1);
      #1;
    end
  endtask

  initial begin
    int reached;
    mdl_reset(0);
    mdl_reset(1);
    for (int c = 0; c < 3; c++) begin
      drive_inputs(100, 50);
      @(negedge clk);
      compare_zero("reset_outputs");
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;

    run_cycles(600, 90, 70);
    run_cycles(600, 98, 12);
    run_cycles(600, 75, 90);

    // Asynchronous reset while the fixed-priority instance is connected.
    reached = 0;
    for (int c = 0; c < 400 && reached == 0; c++) begin
      run_cycles(1, 97, 80);
      if (ph[0] == P_CONN) reached = 1;
    end
    chk("conn_before_reset", 64'(reached), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    compare_zero("async_reset_outputs");
    mdl_reset(0);
    mdl_reset(1);
    @(posedge clk);
    #1;
    compare_zero("held_reset_outputs");
    rstn = 1'b1;

    run_cycles(600, 99, 80);
    run_cycles(300, 85, 50);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
